// File: rtl/btn_event_pkg.sv
// btn_event_pkg: shared constants for the push-button event port.
//   NUM_BTN      - number of buttons, bit order {btnc, btnu, btnd, btnl, btnr}
//   ADDR_*       - register select values on address[2:0]
//   CTRL_*       - bit positions inside the CTRL register
package btn_event_pkg;

  localparam int unsigned NUM_BTN = 5;

  localparam logic [2:0] ADDR_LEVEL   = 3'd0;
  localparam logic [2:0] ADDR_PRESS   = 3'd1;
  localparam logic [2:0] ADDR_RELEASE = 3'd2;
  localparam logic [2:0] ADDR_MASK    = 3'd3;
  localparam logic [2:0] ADDR_CTRL    = 3'd4;

  localparam int unsigned CTRL_RD_CLR = 0;  // read strobe clears PRESS/RELEASE
  localparam int unsigned CTRL_RPT_EN = 1;  // auto-repeat enable

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer plus counter debounce for one raw button.
//   clk, reset_n - clock, asynchronous active-low reset
//   raw          - asynchronous button input (only sampled by the first sync flop)
//   level        - debounced level; follows raw 2 + DEBOUNCE_CYCLES clocks after a stable edge
module btn_debounce
  import btn_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000  // minimum 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic            level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      // Any return to the current level restarts the count, so bounces never accumulate.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntMax) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign level = level_q;

endmodule

// File: rtl/btn_event_port.sv
// btn_event_port: PicoBlaze port-bus responder turning five raw buttons into debounced
// levels, sticky press/release events and a masked one-cycle interrupt pulse.
//   clk, reset_n  - clock, asynchronous active-low reset
//   buttons[4:0]  - raw buttons {btnc, btnu, btnd, btnl, btnr}
//   address[2:0]  - register select: 0 LEVEL, 1 PRESS, 2 RELEASE, 3 MASK, 4 CTRL
//   write, read   - decoded strobes; write_data is the out_port byte
//   read_data     - combinational register data for the current address
//   irq           - one-cycle pulse on any masked press (or repeat) event
// Optional build macro BTN_EVENT_AUTOREPEAT_EN adds per-button hold counters that
// generate auto-repeat press events while CTRL bit1 is set.
module btn_event_port
  import btn_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 12500000,
  parameter int unsigned REPEAT_PERIOD   = 2500000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] buttons,
  input  logic [2:0]         address,
  input  logic               write,
  input  logic               read,
  input  logic [7:0]         write_data,
  output logic [7:0]         read_data,
  output logic               irq
);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_prev_q;
  logic [NUM_BTN-1:0] press_evt, release_evt, rpt_evt, press_set;
  logic [NUM_BTN-1:0] press_q, press_d, release_q, release_d;
  logic [NUM_BTN-1:0] press_clr, release_clr;
  logic [NUM_BTN-1:0] mask_q;
  logic               ctrl_rd_clr_q;
  logic               ctrl_rpt_en;
  logic               irq_q;
  logic [2:0]         unused_wd;

  assign unused_wd = write_data[7:5];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .raw    (buttons[i]),
      .level  (level[i])
    );
  end

  assign press_evt   = level & ~level_prev_q;
  assign release_evt = ~level & level_prev_q;

`ifdef BTN_EVENT_AUTOREPEAT_EN
  // hold_q counts cycles since the press event (press cycle = 0). A repeat fires when it
  // hits REPEAT_DELAY and the counter is reloaded so the next fire is REPEAT_PERIOD later.
  // Assumes REPEAT_PERIOD <= REPEAT_DELAY.
  localparam int unsigned      HoldW      = $clog2(REPEAT_DELAY + 1);
  localparam logic [HoldW-1:0] HoldFire   = HoldW'(REPEAT_DELAY);
  localparam logic [HoldW-1:0] HoldReload = HoldW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic ctrl_rpt_en_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_hold
    logic [HoldW-1:0] hold_q;

    assign rpt_evt[i] = ctrl_rpt_en_q && level[i] && (hold_q == HoldFire);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
      end else if (!ctrl_rpt_en_q || !level[i]) begin
        hold_q <= '0;
      end else if (press_evt[i]) begin
        hold_q <= HoldW'(1);
      end else if (rpt_evt[i]) begin
        hold_q <= HoldReload;
      end else if (hold_q != '0) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_rpt_en_q <= 1'b0;
    end else if (write && (address == ADDR_CTRL)) begin
      ctrl_rpt_en_q <= write_data[CTRL_RPT_EN];
    end
  end

  assign ctrl_rpt_en = ctrl_rpt_en_q;
`else
  logic [31:0] unused_repeat_cfg;

  assign unused_repeat_cfg = REPEAT_DELAY ^ REPEAT_PERIOD;
  assign rpt_evt           = '0;
  assign ctrl_rpt_en       = 1'b0;
`endif

  assign press_set = press_evt | rpt_evt;

  // New events are OR-ed in after the clear so a same-cycle set always wins.
  always_comb begin
    press_clr   = '0;
    release_clr = '0;
    if (write && (address == ADDR_PRESS))   press_clr   = write_data[NUM_BTN-1:0];
    if (write && (address == ADDR_RELEASE)) release_clr = write_data[NUM_BTN-1:0];
    if (read && ctrl_rd_clr_q && (address == ADDR_PRESS))   press_clr   = '1;
    if (read && ctrl_rd_clr_q && (address == ADDR_RELEASE)) release_clr = '1;
    press_d   = (press_q & ~press_clr) | press_set;
    release_d = (release_q & ~release_clr) | release_evt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_prev_q  <= '0;
      press_q       <= '0;
      release_q     <= '0;
      mask_q        <= '0;
      ctrl_rd_clr_q <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      level_prev_q <= level;
      press_q      <= press_d;
      release_q    <= release_d;
      // Only fresh events can pulse irq; pending bits or mask writes never do.
      irq_q        <= |(press_set & mask_q);
      if (write && (address == ADDR_MASK)) mask_q        <= write_data[NUM_BTN-1:0];
      if (write && (address == ADDR_CTRL)) ctrl_rd_clr_q <= write_data[CTRL_RD_CLR];
    end
  end

  always_comb begin
    read_data = '0;
    case (address)
      ADDR_LEVEL:   read_data[NUM_BTN-1:0] = level;
      ADDR_PRESS:   read_data[NUM_BTN-1:0] = press_q;
      ADDR_RELEASE: read_data[NUM_BTN-1:0] = release_q;
      ADDR_MASK:    read_data[NUM_BTN-1:0] = mask_q;
      ADDR_CTRL: begin
        read_data[CTRL_RD_CLR] = ctrl_rd_clr_q;
        read_data[CTRL_RPT_EN] = ctrl_rpt_en;
      end
      default: read_data = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
